fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the processor. Replaces the free-running PC register and PC+4 adder.
- Owns the PC and issues addresses to the synchronous instruction ROM, which has 1-cycle read latency.
- Buffers returned instructions in a small queue and hands them to decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute; a redirect flushes all wrong-path work.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- ADDR_W, 32, PC/address width in bits, >= 3.
- INST_W, 32, instruction width in bits.
- QDEPTH, 4, instruction queue entries, power of 2, >= 2.

Ports:
- clock  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- imem_addr  output  ADDR_W  fetch address presented to the instruction ROM.
- imem_en  output  1  fetch issued this cycle; imem_addr is valid.
- imem_data  input  INST_W  ROM read data, valid the cycle after the matching imem_en.
- redirect_valid  input  1  branch/jump taken; restart fetch at redirect_pc.
- redirect_pc  input  ADDR_W  redirect target.
- inst_out  output  INST_W  instruction at the queue head.
- inst_pc  output  ADDR_W  PC of inst_out.
- inst_pc4  output  ADDR_W  inst_pc + 4, for link and sequential use.
- inst_valid  output  1  queue head is valid.
- inst_ready  input  1  decode accepts the head this cycle.

Behaviour:
- Reset (synchronous, active-high):
  - fetch_pc <= RESET_PC; queue emptied; pending fetch cleared.
  - Outputs while reset is high: inst_valid=0, imem_en=0, imem_addr=RESET_PC, inst_out=0, inst_pc=0.
  - Reset asserted mid-operation discards everything in flight.
- Issue rule:
  - imem_en = !reset && !redirect_valid && (count + pending - pop) < QDEPTH.
  - pop = inst_valid && inst_ready.
  - imem_addr = fetch_pc.
  - On issue: fetch_pc <= fetch_pc + 4, modulo 2^ADDR_W, so the last word address wraps to 0; pending <= 1 and pend_pc <= fetch_pc. Without an issue, pending <= 0.
- Return: when pending=1 in a cycle, {imem_data, pend_pc} is written into the queue at the end of that cycle. The credit rule guarantees the queue never overflows.
- Handshake:
  - inst_valid = (count != 0).
  - The head is held stable until popped.
  - Push and pop in the same cycle leave count unchanged.
- Latency:
  - Issue in cycle C, data in C+1, inst_valid in C+2.
  - First inst_valid occurs 2 cycles after reset deasserts.
  - Steady-state throughput is 1 instruction/cycle while inst_ready=1.
- Redirect:
  - In the redirect cycle: queue flushed; pending return squashed, so it is not enqueued; fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00}; no issue.
  - Redirect has priority over pop, push and issue in the same cycle.
  - The target is issued in N+1 and becomes valid in N+3.
  - Back-to-back redirects: the last one wins.
- Alignment: redirect_pc[1:0] is ignored and forced to 0.
- Full queue: issue is suppressed and fetch_pc holds. When a pop frees a slot, issue resumes in that same cycle.
- Empty queue with inst_ready=1: no pop, no state change.
- Widths: count is $clog2(QDEPTH)+1 bits; the queue pointers wrap modulo QDEPTH.

Decomposition:
- Shared package cpu_pkg holds:
  - RESET_PC default (32'h0040_0000).
  - ADDR_W/INST_W defaults.
  - Word-step constant PC_STEP = 4.
- One sub-module, fetch_queue:
  - Synchronous FIFO, width ADDR_W+INST_W, depth QDEPTH.
  - Ports: push, pop, flush, din, dout, count.
  - Flush has priority over push/pop.
- The fetch_unit top holds the PC, the pending stage and the credit/redirect logic.

Test Plan:
- Reset release, inst_ready=1 constant, ROM returns addr-derived data:
  - imem_addr sequence 0x00400000, 0x00400004, ...
  - inst_valid first high 2 cycles after reset drops, with inst_pc=0x00400000 and inst_pc4=0x00400004.
  - Thereafter 1 instruction/cycle.
- inst_ready=0 held, QDEPTH=4:
  - Exactly 4 issues, then imem_en=0 and count=4 with no overflow.
  - Raise inst_ready: the head pops with inst_pc=0x00400000 and issue resumes in the same cycle.
- Redirect to 0x00400103 with 3 entries queued and 1 pending:
  - Next cycle inst_valid=0 and imem_addr=0x00400100.
  - The first valid has inst_pc=0x00400100 at N+3.
  - No pre-redirect instruction is ever presented.
- Redirect, inst_ready and a pending return in the same cycle: the redirect wins and the queue ends empty. Back-to-back redirects to 0x10 then 0x20: the first issue is 0x20.
- Redirect to 0xFFFFFFF8 with inst_ready=1: the issue sequence is 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Reset asserted mid-stream with a full queue: the next cycle has inst_valid=0 and imem_en=0. After release, fetch restarts at 0x00400000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared processor constants used by the fetch front end.
package cpu_pkg;
  localparam int          ADDR_W_DEF   = 32;
  localparam int          INST_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
  localparam int          PC_STEP      = 4;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous instruction FIFO; flush takes priority over push and pop.
module fetch_queue #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only entries below count are ever observed.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  assign dout  = mem[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, one-deep ROM pending stage, credit-limited
// issue into a small queue, and redirect flush.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int                INST_W   = INST_W_DEF,
  parameter int                QDEPTH   = 4
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_en,
  input  logic [INST_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] inst_pc4,
  output logic              inst_valid,
  input  logic              inst_ready
);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int QW = ADDR_W + INST_W;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, pend_pc_q, pend_pc_d;
  logic              pending_q, pending_d;
  logic [CW-1:0]     count;
  logic [CW:0]       inflight;
  logic [QW-1:0]     q_din, q_dout;
  logic              pop, push, issue;

  assign inst_valid = !reset && (count != '0);
  assign pop        = inst_valid && inst_ready;
  assign push       = pending_q && !redirect_valid;

  // Entries held plus the one in flight, less the one leaving this cycle.
  assign inflight = {1'b0, count} + (CW+1)'(pending_q) - (CW+1)'(pop);
  assign issue    = !reset && !redirect_valid && (inflight < (CW+1)'(QDEPTH));

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    pending_d  = issue;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
      pend_pc_d  = fetch_pc_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= '0;
      pending_q  <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      pending_q  <= pending_d;
    end
  end

  assign q_din = {imem_data, pend_pc_q};

  fetch_queue #(.W(QW), .DEPTH(QDEPTH)) u_queue (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (q_din),
    .dout  (q_dout),
    .count (count)
  );

  assign imem_en   = issue;
  assign imem_addr = reset ? RESET_PC : fetch_pc_q;
  assign inst_out  = reset ? '0 : q_dout[ADDR_W +: INST_W];
  assign inst_pc   = reset ? '0 : q_dout[ADDR_W-1:0];
  assign inst_pc4  = inst_pc + ADDR_W'(PC_STEP);
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle synchronous ROM model.
module tb_fetch_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_data = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] inst_out, inst_pc, inst_pc4;
  logic        inst_valid;
  logic        inst_ready;

  int n_chk  = 0;
  int n_fail = 0;
  int n_issue;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0040_0000), .INST_W(32), .QDEPTH(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_en        (imem_en),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .inst_pc4       (inst_pc4),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  always @(posedge clock) if (imem_en) imem_data <= rom(imem_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;

    // Reset release and streaming
    repeat (3) step();
    chk("rst_valid", inst_valid, 0);
    chk("rst_en",    imem_en,    0);
    chk("rst_addr",  imem_addr,  32'h0040_0000);
    chk("rst_out",   inst_out,   0);
    chk("rst_pc",    inst_pc,    0);
    reset = 1'b0; #1;
    chk("s0_en",    imem_en,    1);
    chk("s0_addr",  imem_addr,  32'h0040_0000);
    chk("s0_valid", inst_valid, 0);
    step();
    chk("s1_addr",  imem_addr,  32'h0040_0004);
    chk("s1_valid", inst_valid, 0);
    step();
    chk("s2_valid", inst_valid, 1);
    chk("s2_pc",    inst_pc,    32'h0040_0000);
    chk("s2_pc4",   inst_pc4,   32'h0040_0004);
    chk("s2_out",   inst_out,   rom(32'h0040_0000));
    chk("s2_addr",  imem_addr,  32'h0040_0008);
    for (int k = 3; k < 8; k++) begin
      step();
      chk("str_valid", inst_valid, 1);
      chk("str_pc",    inst_pc,    32'h0040_0000 + 4*(k-2));
      chk("str_addr",  imem_addr,  32'h0040_0000 + 4*k);
    end

    // Backpressure: exactly QDEPTH issues, then resume on pop
    reset = 1'b1; inst_ready = 1'b0; step();
    reset = 1'b0; #1;
    n_issue = 0;
    for (int k = 0; k < 8; k++) begin
      n_issue += int'(imem_en);
      if (k < 7) step();
    end
    chk("bp_issues", n_issue,    4);
    chk("bp_en",     imem_en,    0);
    chk("bp_valid",  inst_valid, 1);
    chk("bp_head",   inst_pc,    32'h0040_0000);
    step();
    inst_ready = 1'b1; #1;
    chk("bp_pop_pc", inst_pc,   32'h0040_0000);
    chk("bp_res_en", imem_en,   1);
    chk("bp_res_ad", imem_addr, 32'h0040_0010);
    for (int k = 9; k < 13; k++) begin
      step();
      chk("bp_drain_pc", inst_pc, 32'h0040_0000 + 4*(k-8));
    end

    // Redirect with 3 queued and 1 pending
    reset = 1'b1; inst_ready = 1'b0; step();
    reset = 1'b0; #1;
    repeat (4) step();
    chk("rd_full_en", imem_en, 0);
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0103; #1;
    chk("rd_n_en", imem_en, 0);
    step();
    redirect_valid = 1'b0; inst_ready = 1'b1; #1;
    chk("rd_n1_valid", inst_valid, 0);
    chk("rd_n1_en",    imem_en,    1);
    chk("rd_n1_addr",  imem_addr,  32'h0040_0100);
    step();
    chk("rd_n2_valid", inst_valid, 0);
    chk("rd_n2_addr",  imem_addr,  32'h0040_0104);
    step();
    chk("rd_n3_valid", inst_valid, 1);
    chk("rd_n3_pc",    inst_pc,    32'h0040_0100);
    chk("rd_n3_out",   inst_out,   rom(32'h0040_0100));
    step();
    chk("rd_n4_pc",    inst_pc,    32'h0040_0104);

    // Redirect against pop+pending, then back-to-back redirects
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0010; #1;
    chk("bb_en0", imem_en, 0);
    step();
    redirect_pc = 32'h0000_0020; #1;
    chk("bb_empty", inst_valid, 0);
    chk("bb_en1",   imem_en,    0);
    step();
    redirect_valid = 1'b0; #1;
    chk("bb_valid", inst_valid, 0);
    chk("bb_en2",   imem_en,    1);
    chk("bb_addr",  imem_addr,  32'h0000_0020);
    step(); step();
    chk("bb_first_pc", inst_pc, 32'h0000_0020);

    // Address wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; #1;
    step();
    redirect_valid = 1'b0; #1;
    chk("wr_a0", imem_addr, 32'hFFFF_FFF8);
    step();
    chk("wr_a1", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wr_a2",  imem_addr, 32'h0000_0000);
    chk("wr_pc0", inst_pc,   32'hFFFF_FFF8);
    step();
    chk("wr_pc1",  inst_pc,  32'hFFFF_FFFC);
    chk("wr_pc4",  inst_pc4, 32'h0000_0000);

    // Reset with a full queue
    inst_ready = 1'b0;
    repeat (8) step();
    chk("mr_full_en",  imem_en,    0);
    chk("mr_full_vld", inst_valid, 1);
    reset = 1'b1; #1;
    chk("mr_valid0", inst_valid, 0);
    chk("mr_en0",    imem_en,    0);
    step();
    chk("mr_valid1", inst_valid, 0);
    chk("mr_en1",    imem_en,    0);
    reset = 1'b0; inst_ready = 1'b1; #1;
    chk("mr_en2",   imem_en,   1);
    chk("mr_addr",  imem_addr, 32'h0040_0000);
    step(); step();
    chk("mr_valid", inst_valid, 1);
    chk("mr_pc",    inst_pc,    32'h0040_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
